// File: rtl/operand_fetch_if.sv
// Decode-to-execute bus of the operand fetch stage, including the regfile read
// port and the writeback bus the stage snoops.
interface operand_fetch_if;
    logic        id_valid_i;
    logic        id_ready_o;
    logic [4:0]  id_rs1_i;
    logic [4:0]  id_rs2_i;
    logic        id_use1_i;
    logic        id_use2_i;
    logic [4:0]  id_rd_i;
    logic        id_we_i;
    logic [31:0] id_ctrl_i;

    logic [4:0]  raddra_o;
    logic [4:0]  raddrb_o;
    logic [31:0] rdataa_i;
    logic [31:0] rdatab_i;

    logic        wb_write_i;
    logic [4:0]  wb_waddr_i;
    logic [31:0] wb_wdata_i;

    logic        flush_i;

    logic        ex_valid_o;
    logic        ex_ready_i;
    logic [31:0] ex_op_a_o;
    logic [31:0] ex_op_b_o;
    logic [4:0]  ex_rd_o;
    logic        ex_we_o;
    logic [31:0] ex_ctrl_o;

    modport slave (
        input  id_valid_i, id_rs1_i, id_rs2_i, id_use1_i, id_use2_i,
        input  id_rd_i, id_we_i, id_ctrl_i,
        input  rdataa_i, rdatab_i,
        input  wb_write_i, wb_waddr_i, wb_wdata_i,
        input  flush_i, ex_ready_i,
        output id_ready_o, raddra_o, raddrb_o,
        output ex_valid_o, ex_op_a_o, ex_op_b_o, ex_rd_o, ex_we_o, ex_ctrl_o
    );

    modport master (
        output id_valid_i, id_rs1_i, id_rs2_i, id_use1_i, id_use2_i,
        output id_rd_i, id_we_i, id_ctrl_i,
        output rdataa_i, rdatab_i,
        output wb_write_i, wb_waddr_i, wb_wdata_i,
        output flush_i, ex_ready_i,
        input  id_ready_o, raddra_o, raddrb_o,
        input  ex_valid_o, ex_op_a_o, ex_op_b_o, ex_rd_o, ex_we_o, ex_ctrl_o
    );
endinterface

// File: rtl/operand_fetch.sv
// rv32i issue / operand-fetch stage: scoreboarded hazard check, optional
// writeback bypass and a valid/ready output register towards execute.
module operand_fetch #(
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    operand_fetch_if.slave bus
);

    logic [31:0] sb_q, sb_d;

    logic        ex_valid_q, ex_valid_d;
    logic [31:0] ex_op_a_q, ex_op_a_d;
    logic [31:0] ex_op_b_q, ex_op_b_d;
    logic [4:0]  ex_rd_q, ex_rd_d;
    logic        ex_we_q, ex_we_d;
    logic [31:0] ex_ctrl_q, ex_ctrl_d;

    logic [4:0]  src_idx   [2];
    logic        src_use   [2];
    logic [31:0] src_rdata [2];
    logic        src_hit   [2];
    logic        src_blk   [2];
    logic [31:0] src_opnd  [2];

    logic waw_blk;
    logic stall;
    logic id_ready;
    logic issue;

    assign src_idx[0]   = bus.id_rs1_i;
    assign src_idx[1]   = bus.id_rs2_i;
    assign src_use[0]   = bus.id_use1_i;
    assign src_use[1]   = bus.id_use2_i;
    assign src_rdata[0] = bus.rdataa_i;
    assign src_rdata[1] = bus.rdatab_i;

    assign bus.raddra_o = bus.id_rs1_i;
    assign bus.raddrb_o = bus.id_rs2_i;

    // Per-source hazard check and operand mux; x0 always reads as zero.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = bus.wb_write_i && (bus.wb_waddr_i == src_idx[gi])
                                 && (src_idx[gi] != 5'd0);
            assign src_blk[gi] = src_use[gi] && sb_q[src_idx[gi]]
                                 && !(BYPASS_EN && src_hit[gi]);

            always_comb begin
                src_opnd[gi] = src_rdata[gi];
                if (src_idx[gi] == 5'd0) begin
                    src_opnd[gi] = 32'd0;
                end else if (BYPASS_EN && src_hit[gi]) begin
                    src_opnd[gi] = bus.wb_wdata_i;
                end
            end
        end
    endgenerate

    // A retiring write to rd does not lift the WAW block in the same cycle.
    assign waw_blk  = bus.id_we_i && (bus.id_rd_i != 5'd0) && sb_q[bus.id_rd_i];
    assign stall    = src_blk[0] || src_blk[1] || waw_blk;
    assign id_ready = !bus.flush_i && !stall && (!ex_valid_q || bus.ex_ready_i);
    assign issue    = bus.id_valid_i && id_ready;

    assign bus.id_ready_o = id_ready;

    // Scoreboard: flush clears all, a new issue beats a same-cycle retire.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_sb
            if (gi == 0) begin : g_zero
                assign sb_d[gi] = 1'b0;
            end else begin : g_bit
                logic set_hit;
                logic clr_hit;
                assign set_hit = issue && bus.id_we_i && (bus.id_rd_i == 5'(gi));
                assign clr_hit = bus.wb_write_i && (bus.wb_waddr_i == 5'(gi));

                always_comb begin
                    sb_d[gi] = sb_q[gi];
                    if (bus.flush_i) begin
                        sb_d[gi] = 1'b0;
                    end else if (set_hit) begin
                        sb_d[gi] = 1'b1;
                    end else if (clr_hit) begin
                        sb_d[gi] = 1'b0;
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_op_a_d  = ex_op_a_q;
        ex_op_b_d  = ex_op_b_q;
        ex_rd_d    = ex_rd_q;
        ex_we_d    = ex_we_q;
        ex_ctrl_d  = ex_ctrl_q;
        if (bus.flush_i) begin
            ex_valid_d = 1'b0;
        end else if (issue) begin
            ex_valid_d = 1'b1;
            ex_op_a_d  = src_opnd[0];
            ex_op_b_d  = src_opnd[1];
            ex_rd_d    = bus.id_rd_i;
            ex_we_d    = bus.id_we_i;
            ex_ctrl_d  = bus.id_ctrl_i;
        end else if (bus.ex_ready_i) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sb_q       <= '0;
            ex_valid_q <= 1'b0;
            ex_op_a_q  <= '0;
            ex_op_b_q  <= '0;
            ex_rd_q    <= '0;
            ex_we_q    <= 1'b0;
            ex_ctrl_q  <= '0;
        end else begin
            sb_q       <= sb_d;
            ex_valid_q <= ex_valid_d;
            ex_op_a_q  <= ex_op_a_d;
            ex_op_b_q  <= ex_op_b_d;
            ex_rd_q    <= ex_rd_d;
            ex_we_q    <= ex_we_d;
            ex_ctrl_q  <= ex_ctrl_d;
        end
    end

    assign bus.ex_valid_o = ex_valid_q;
    assign bus.ex_op_a_o  = ex_op_a_q;
    assign bus.ex_op_b_o  = ex_op_b_q;
    assign bus.ex_rd_o    = ex_rd_q;
    assign bus.ex_we_o    = ex_we_q;
    assign bus.ex_ctrl_o  = ex_ctrl_q;

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Issue and operand-fetch stage of the rv32i pipeline. It sits between decode and execute and is the read-side consumer of `regfile`. It drives `regfile` read addresses and captures `rs1`/`rs2` operands. A 32-entry scoreboard tracks destination registers with writes still in flight, so dependent instructions stall until the writeback bus (the same bus that drives the `regfile` write port) retires them, with optional same-cycle bypass. Results go into a valid/ready pipeline register feeding execute.

## Interface
- `BYPASS_EN`, default 1: 1 forwards `wb_wdata_i` to a waiting source in the writeback cycle; 0 stalls one extra cycle instead.
- `clk_i`  in  1  clock, rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `id_valid_i`  in  1  decode presents an instruction.
- `id_ready_o`  out  1  stage accepts the instruction this cycle.
- `id_rs1_i`, `id_rs2_i`  in  5 each  source register indices.
- `id_use1_i`, `id_use2_i`  in  1 each  instruction reads rs1 / rs2.
- `id_rd_i`  in  5  destination index.
- `id_we_i`  in  1  instruction writes rd.
- `id_ctrl_i`  in  32  opaque control sideband, passed through.
- `raddra_o`, `raddrb_o`  out  5 each  `regfile` read addresses.
- `rdataa_i`, `rdatab_i`  in  32 each  `regfile` read data (combinational).
- `wb_write_i`  in  1  writeback strobe (same net as `regfile` `write_i`).
- `wb_waddr_i`  in  5  writeback address.
- `wb_wdata_i`  in  32  writeback data.
- `flush_i`  in  1  squash held instruction and clear scoreboard.
- `ex_valid_o`  out  1  operands valid to execute.
- `ex_ready_i`  in  1  execute accepts.
- `ex_op_a_o`, `ex_op_b_o`  out  32 each  rs1 / rs2 operand values.
- `ex_rd_o`  out  5  destination register.
- `ex_we_o`  out  1  destination write enable.
- `ex_ctrl_o`  out  32  control sideband.

## Operation
- Read addresses are combinational: `raddra_o = id_rs1_i`, `raddrb_o = id_rs2_i`, regardless of `id_valid_i`.
- Scoreboard `sb[31:0]`:
  - `sb[0]` is hardwired 0.
  - Set `sb[rd]` on issue when `id_we_i=1` and `rd!=0`. Issue is `id_valid_i & id_ready_o`.
  - Clear `sb[wb_waddr_i]` when `wb_write_i=1`.
  - If set and clear hit the same index in one cycle, set wins.
- Bypass hit for source s: `wb_write_i & (wb_waddr_i==rs_s) & (rs_s!=0)`.
- Source s is blocked when `id_use_s` is set and `sb[rs_s]` is set, unless `BYPASS_EN=1` and bypass hit.
- WAW block: `id_we_i` set, `rd!=0` and `sb[rd]` set. A clear from `wb_write_i` in the same cycle does not unblock.
- `stall` = any source blocked, or WAW block.
- `id_ready_o = !flush_i & !stall & (!ex_valid_o | ex_ready_i)`.
- Operand select per source:
  - s==0 gives 0.
  - Else, with `BYPASS_EN=1` and bypass hit, gives `wb_wdata_i`.
  - Else gives `rdata`.
  - Unused sources still carry the selected value.
- Output register:
  - On issue, load operands, `rd`, `we`, `ctrl`, and set `ex_valid_o`.
  - Else, if `ex_ready_i` is high, clear `ex_valid_o`.
  - Else hold all outputs stable.
- Flush has priority: next cycle `ex_valid_o=0` and `sb=0`. Issue is suppressed in the flush cycle. The environment guarantees that writebacks of squashed instructions never assert `wb_write_i`.

## Timing
- Reset (asynchronous): `ex_valid_o=0`, `ex_op_a_o=ex_op_b_o=0`, `ex_rd_o=0`, `ex_we_o=0`, `ex_ctrl_o=0`, `sb=0`.
- `id_ready_o` follows from the reset state (1 while not flushing).
- Reset mid-operation discards the held instruction and all scoreboard state.
- Latency is 1 cycle: issue at edge N gives `ex_valid_o=1` after edge N.
- Throughput is 1 instruction/cycle with no hazards and `ex_ready_i=1`.
- RAW with `BYPASS_EN=1`: the dependent instruction issues in the same cycle its producer asserts `wb_write_i`.
- RAW with `BYPASS_EN=0`: issue is 1 cycle later, because `regfile` then holds the value.
- Backpressure: while `ex_valid_o & !ex_ready_i`, outputs are stable and `id_ready_o=0`.

## Test plan
- Reset then back-to-back independent ops (rs=1,2 holding 0x11/0x22, rd=3..6) -> one issue per cycle; `ex_op_a_o=0x11`, `ex_op_b_o=0x22`.
- Issue rd=5; next op uses rs1=5; wb of x5=0xDEAD arrives 3 cycles later -> stalled until the wb cycle.
  - `BYPASS_EN=1`: issues that cycle with `ex_op_a_o=0xDEAD`.
  - `BYPASS_EN=0`: issues one cycle later with the same value.
- rs1=rs2=0 with a wb to x0 of 0xFFFFFFFF -> operands 0, no stall; rd=0 write never sets the scoreboard.
- WAW: issue rd=7, then another rd=7 -> second waits for wb of x7. Then a set and clear of x7 in the same cycle -> `sb[7]=1`.
- Hold `ex_ready_i=0` for 4 cycles with a valid op -> outputs unchanged, `id_ready_o=0`; release -> next op issues.
- `flush_i` pulse with `sb[9]` set and a valid output -> next cycle `ex_valid_o=0`; a subsequent op reading x9 issues without stall.
